// File: rtl/mdu_pkg.sv
// Shared MD-class definitions: op encodings, default latencies, FSM states and the HI/LO pair.
// Also included by the D-stage decoder and the stall controller.
package mdu_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_res_t;

   // Ops 0-3 launch a multi-cycle operation; everything else never does.
   function automatic logic is_calc_op(input logic [2:0] op);
      return !op[2];
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational mult/multu/div/divu datapath producing the {hi,lo} pair plus a div-by-zero flag.
// Zero latency; no flow control, the caller decides when to sample.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output md_res_t     res,
   output logic        div_zero
);

   logic        [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] b_nz;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic        [31:0] quo_u;
   logic        [31:0] rem_u;

   assign div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

   // Substitute a harmless divisor so the dividers never see zero; the result is discarded anyway.
   assign b_nz = (b == 32'd0) ? 32'd1 : b;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};
   assign quo_s  = $signed(a) / $signed(b_nz);
   assign rem_s  = $signed(a) % $signed(b_nz);
   assign quo_u  = a / b_nz;
   assign rem_u  = a % b_nz;

   always_comb begin
      res = '0;
      case (op)
         MD_MULT:  res = prod_s;
         MD_MULTU: res = prod_u;
         MD_DIV: begin
            res.hi = rem_s;
            res.lo = quo_s;
         end
         MD_DIVU: begin
            res.hi = rem_u;
            res.lo = quo_u;
         end
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO; mthi/mtlo write in one cycle.
// mult: busy 5 cycles, div: busy 10 cycles; requests during busy are dropped (stall controller holds them off).
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        md_we,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   md_res_t          pend_q, pend_d;
   logic             pend_wr_q, pend_wr_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   md_res_t          calc_res;
   logic             calc_div_zero;

   mdu_calc u_calc (
      .op       (md_op),
      .a        (a),
      .b        (b),
      .res      (calc_res),
      .div_zero (calc_div_zero)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start && is_calc_op(md_op)) begin
               state_d   = ST_RUN;
               cnt_d     = md_op[1] ? DIV_CNT : MULT_CNT;
               pend_d    = calc_res;
               pend_wr_d = !calc_div_zero;
            end else if (md_we && (md_op == MD_MTHI)) begin
               hi_d = a;
            end else if (md_we && (md_op == MD_MTLO)) begin
               lo_d = a;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - 1'b1;
            // <= rather than == so a zero count can never trap the FSM in RUN.
            if (cnt_q <= 1) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (pend_wr_q) begin
                  hi_d = pend_q.hi;
                  lo_d = pend_q.lo;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: an arithmetic HI/LO model checked every cycle plus literal expectations.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic        md_we;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .md_we (md_we),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
   endtask

   // Model: remaining busy cycles and the value that lands in HI/LO when they run out.
   int          m_left = 0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   bit          p_wr = 1'b0;

   always @(posedge clk) begin : model_p
      logic [63:0] prod;
      int          qa, qb;
      if (!reset) begin
         m_left = 0;
         m_hi   = '0;
         m_lo   = '0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && p_wr) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (start && md_op < 3'd4) begin
         p_wr = 1'b1;
         case (md_op)
            3'd0: begin
               prod = 64'(longint'($signed(a)) * longint'($signed(b)));
               {p_hi, p_lo} = prod;
               m_left = 5;
            end
            3'd1: begin
               prod = {32'd0, a} * {32'd0, b};
               {p_hi, p_lo} = prod;
               m_left = 5;
            end
            3'd2: begin
               if (b == 0) p_wr = 1'b0;
               else begin
                  qa = $signed(a);
                  qb = $signed(b);
                  p_lo = qa / qb;
                  p_hi = qa % qb;
               end
               m_left = 10;
            end
            default: begin
               if (b == 0) p_wr = 1'b0;
               else begin
                  p_lo = a / b;
                  p_hi = a % b;
               end
               m_left = 10;
            end
         endcase
      end else if (md_we && md_op == 3'd4) begin
         m_hi = a;
      end else if (md_we && md_op == 3'd5) begin
         m_lo = a;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy_vs_model", busy, (m_left > 0));
         chk("hi_vs_model", hi, m_hi);
         chk("lo_vs_model", lo, m_lo);
      end
   end

   // Called on a negedge; returns on the negedge of the first cycle with busy low again.
   task automatic launch(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int n);
      start = 1'b1;
      md_op = op;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      md_op = 3'd7;
      a     = '0;
      b     = '0;
      n     = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b0;
      start = 1'b0;
      md_we = 1'b0;
      md_op = 3'd7;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_hilo", {hi, lo}, 64'h0);
      reset  = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      launch(MD_MULT, 32'hFFFF_FFFE, 32'd3, n);
      chk("mult_busy_cycles", n, 5);
      chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("model_mult", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

      // Back-to-back: issued in the first idle cycle.
      launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      chk("multu_busy_cycles", n, 5);
      chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      chk("model_multu", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);

      launch(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
      chk("div_busy_cycles", n, 10);
      chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("model_div", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      launch(MD_DIVU, 32'd7, 32'd0, n);
      chk("divu0_busy_cycles", n, 10);
      chk("divu0_hilo_kept", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      launch(MD_DIV, 32'd7, 32'hFFFF_FFFE, n);
      chk("div_negb_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

      md_we = 1'b1;
      md_op = MD_MTHI;
      a     = 32'h1234_5678;
      @(negedge clk);
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_lo_kept", lo, 32'hFFFF_FFFD);
      chk("mthi_busy", busy, 0);
      md_op = MD_MTLO;
      a     = 32'h9ABC_DEF0;
      @(negedge clk);
      md_we = 1'b0;
      md_op = 3'd7;
      a     = '0;
      chk("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
      chk("mtlo_busy", busy, 0);

      // start and md_we together: the start wins.
      md_we = 1'b1;
      launch(MD_MULT, 32'd6, 32'd7, n);
      md_we = 1'b0;
      chk("start_wins_cycles", n, 5);
      chk("start_wins_hilo", {hi, lo}, 64'h0000_0000_0000_002A);

      start = 1'b1;
      md_op = 3'd6;
      a     = 32'd55;
      b     = 32'd2;
      @(negedge clk);
      start = 1'b0;
      md_op = 3'd7;
      chk("bad_op_busy", busy, 0);
      @(negedge clk);
      chk("bad_op_hilo", {hi, lo}, 64'h0000_0000_0000_002A);

      // div 100/7 with a stray start at T+3 and a stray mthi at T+4.
      start = 1'b1;
      md_op = MD_DIV;
      a     = 32'd100;
      b     = 32'd7;
      n     = 0;
      @(negedge clk);
      start = 1'b0;
      md_op = 3'd7;
      for (int c = 1; c <= 20; c++) begin
         if (busy) n++;
         if (c == 3) begin
            start = 1'b1;
            md_op = MD_MULT;
            a     = 32'd3;
            b     = 32'd5;
         end else if (c == 4) begin
            start = 1'b0;
            md_we = 1'b1;
            md_op = MD_MTHI;
            a     = 32'hDEAD_BEEF;
         end else if (c == 5) begin
            md_we = 1'b0;
            md_op = 3'd7;
            a     = '0;
         end
         if (c == 10) chk("run_ign_precommit", {hi, lo}, 64'h0000_0000_0000_002A);
         if (c == 11) begin
            chk("run_ign_commit", {hi, lo}, 64'h0000_0002_0000_000E);
            chk("run_ign_idle", busy, 0);
         end
         @(negedge clk);
      end
      chk("run_ign_busy_total", n, 10);

      start = 1'b1;
      md_op = MD_MULT;
      a     = 32'd3;
      b     = 32'd4;
      @(negedge clk);
      start = 1'b0;
      md_op = 3'd7;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midrun_reset_busy", busy, 0);
      chk("midrun_reset_hilo", {hi, lo}, 64'h0);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      chk("midrun_no_commit", {hi, lo}, 64'h0);
      chk("midrun_idle", busy, 0);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
